// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational double-precision adder
// between two requesters over valid/ready handshakes.
module fp_adder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    logic        a_nan, b_nan, a_inf, b_inf, swap, sub, up;
    logic [63:0] x, z;
    logic [11:0] ex, ez, d, e, ef;
    logic [55:0] mx, mz, mzs, m, mask;
    logic [56:0] sum;
    logic [5:0]  lz, sh;
    logic [53:0] mr;

    function automatic logic [5:0] lzc56(input logic [55:0] v);
        lzc56 = 6'd56;
        for (int i = 0; i < 56; i++)
            if (v[i]) lzc56 = 6'(55 - i);
    endfunction

    always_comb begin
        a_nan = (&a[62:52]) & (|a[51:0]);
        b_nan = (&b[62:52]) & (|b[51:0]);
        a_inf = (&a[62:52]) & ~(|a[51:0]);
        b_inf = (&b[62:52]) & ~(|b[51:0]);
        swap  = b[62:0] > a[62:0];
        x     = swap ? b : a;
        z     = swap ? a : b;
        sub   = x[63] ^ z[63];
        ex    = (x[62:52] == 11'd0) ? 12'd1 : {1'b0, x[62:52]};
        ez    = (z[62:52] == 11'd0) ? 12'd1 : {1'b0, z[62:52]};
        mx    = {|x[62:52], x[51:0], 3'b000};
        mz    = {|z[62:52], z[51:0], 3'b000};
        d     = ex - ez;
        mask  = ~({56{1'b1}} << d[5:0]);
        if (d >= 12'd56)
            mzs = {55'd0, |mz};
        else
            mzs = (mz >> d[5:0]) | {55'd0, |(mz & mask)};
        sum = sub ? {1'b0, mx} - {1'b0, mzs}
                  : {1'b0, mx} + {1'b0, mzs};
        lz = lzc56(sum[55:0]);
        sh = 6'd0;
        if (sum[56]) begin
            m = sum[56:1] | {55'd0, sum[0]};
            e = ex + 12'd1;
        end else begin
            if ({6'd0, lz} < ex) sh = lz;
            else                 sh = 6'(ex - 12'd1);
            m = sum[55:0] << sh;
            e = ex - {6'd0, sh};
        end
        // round to nearest, ties to even; guard/round/sticky in m[2:0]
        ef = m[55] ? e : 12'd0;
        up = m[2] & (m[1] | m[0] | m[3]);
        mr = {1'b0, m[55:3]} + {53'd0, up};
        if (mr[53]) begin
            ef = ef + 12'd1;
            mr = mr >> 1;
        end else if (ef == 12'd0 && mr[52]) begin
            ef = 12'd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && sub))
            y = 64'h7FF8_0000_0000_0000;
        else if (a_inf)
            y = a;
        else if (b_inf)
            y = b;
        else if (sum == 57'd0)
            y = {x[63] & z[63], 63'd0};
        else if (ef >= 12'd2047)
            y = {x[63], 11'h7FF, 52'd0};
        else
            y = {x[63], ef[10:0], mr[51:0]};
    end
endmodule

module fp_add_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [63:0]      req_a0,
    input  logic [63:0]      req_b0,
    input  logic [63:0]      req_a1,
    input  logic [63:0]      req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [63:0]      resp_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state;
    logic        rr_ptr, owner, gnt;
    logic [63:0] op_a, op_b, res_q, sum;

    fp_adder u_add (.a(op_a), .b(op_b), .y(sum));

    always_comb begin
        gnt = (&req_valid) ? rr_ptr : req_valid[1];
        req_ready = 2'b00;
        if (state == IDLE && |req_valid)
            req_ready = gnt ? 2'b10 : 2'b01;
    end

    assign resp_result = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            res_q      <= '0;
            op_count   <= '0;
            busy       <= 1'b0;
            resp_valid <= 2'b00;
        end else begin
            unique case (state)
                IDLE: if (|(req_valid & req_ready)) begin
                    op_a  <= gnt ? req_a1 : req_a0;
                    op_b  <= gnt ? req_b1 : req_b0;
                    owner <= gnt;
                    busy  <= 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    res_q      <= sum;
                    resp_valid <= owner ? 2'b10 : 2'b01;
                    state      <= DONE;
                end
                DONE: if (resp_ready[owner]) begin
                    rr_ptr     <= ~owner;
                    busy       <= 1'b0;
                    resp_valid <= 2'b00;
                    state      <= IDLE;
                    if (~&op_count)
                        op_count <= op_count + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
